// File: rtl/osd_cmd_tx.sv
// rtl/osd_cmd_tx.sv - OSD overlay port command transmitter
// Serialises DISABLE / ENABLE / ENABLE_INFO / WRITE requests onto io_osd/io_strobe/io_din.
module osd_cmd_tx #(
  parameter int STB_HI = 2,
  parameter int STB_LO = 2,
  parameter int GAP    = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  wr_blk,
  input  logic        wr_hires,
  input  logic [12:0] wr_len,
  input  logic [11:0] info_x,
  input  logic [11:0] info_y,
  input  logic [5:0]  info_w,
  input  logic [5:0]  info_h,
  output logic [11:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam logic [1:0] OP_DISABLE     = 2'd0;
  localparam logic [1:0] OP_ENABLE      = 2'd1;
  localparam logic [1:0] OP_ENABLE_INFO = 2'd2;
  localparam logic [1:0] OP_WRITE       = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  localparam logic [15:0] HI_LOAD  = 16'(STB_HI - 1);
  localparam logic [15:0] LO_LOAD  = 16'(STB_LO - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [12:0] word_idx;
  logic [12:0] last_idx;
  logic [1:0]  op_q;
  logic [3:0]  blk_q;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic [5:0]  w_q;
  logic [5:0]  h_q;

  logic [12:0] len_sat;
  logic [12:0] payload_words;
  logic [7:0]  cmd_byte;
  logic [15:0] next_word;
  logic        more_words;

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign more_words = (word_idx != last_idx);
  assign len_sat    = (wr_len > 13'd4096) ? 13'd4096 : wr_len;

  always_comb begin
    cmd_byte      = 8'h40;
    payload_words = 13'd0;
    case (cmd_op)
      OP_DISABLE:     cmd_byte = 8'h40;
      OP_ENABLE:      cmd_byte = 8'h41;
      OP_ENABLE_INFO: begin
        cmd_byte      = 8'h45;
        payload_words = 13'd4;
      end
      default: begin
        // wr_blk[3] and the highres flag share bit 3 of the command byte
        cmd_byte      = 8'h20 | {4'h0, wr_hires, 3'b000} | {4'h0, wr_blk};
        payload_words = len_sat;
      end
    endcase
  end

  // word_idx names the word currently on the wire; this is the one after it
  always_comb begin
    next_word = 16'h0000;
    if (op_q == OP_WRITE) begin
      next_word = {8'h00, src_data};
    end else if (op_q == OP_ENABLE_INFO) begin
      case (word_idx[1:0])
        2'd0:    next_word = {4'h0, x_q};
        2'd1:    next_word = {4'h0, y_q};
        2'd2:    next_word = {10'h000, w_q};
        default: next_word = {10'h000, h_q};
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      word_idx  <= 13'd0;
      last_idx  <= 13'd0;
      op_q      <= 2'd0;
      blk_q     <= 4'd0;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      w_q       <= 6'd0;
      h_q       <= 6'd0;
      src_addr  <= 12'd0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            blk_q    <= wr_blk;
            x_q      <= info_x;
            y_q      <= info_y;
            w_q      <= info_w;
            h_q      <= info_h;
            last_idx <= payload_words;
            word_idx <= 13'd0;
            io_osd   <= 1'b1;
            io_din   <= {8'h00, cmd_byte};
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          io_strobe <= 1'b1;
          cnt       <= HI_LOAD;
          state     <= S_HI;
        end

        S_HI: begin
          if (cnt == 16'd0) begin
            io_strobe <= 1'b0;
            cnt       <= LO_LOAD;
            state     <= S_LO;
            // Address is presented for the whole first LO cycle so the
            // registered RAM data is ready by the last LO cycle.
            if (op_q == OP_WRITE && more_words)
              src_addr <= {blk_q, 8'h00} + word_idx[11:0];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        S_LO: begin
          if (cnt == 16'd0) begin
            if (more_words) begin
              word_idx  <= word_idx + 13'd1;
              io_din    <= next_word;
              io_strobe <= 1'b1;
              cnt       <= HI_LOAD;
              state     <= S_HI;
            end else begin
              io_osd <= 1'b0;
              io_din <= 16'h0000;
              cnt    <= GAP_LOAD;
              state  <= S_END;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        S_END: begin
          if (cnt == 16'd0)
            state <= S_IDLE;
          else
            cnt <= cnt - 16'd1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
